sistema_mem_02: RTL and testbench
=================================

# sistema_mem_02

Parametrised multi-bank memory subsystem with an integrated address decoder, request/ready handshake and an error response path. It replaces the single-bank, always-ready memory system. The address window is split into N_BANKS equal banks, each with a one-hot chip-select. Out-of-window accesses and writes to write-protected banks are rejected with an error flag and counted. It sits between a simple bus master (CPU or testbench driver) and the on-chip RAM banks.

## Interface
- DATA_W, 8: data word width.
- ADDR_W, 16: bus address width.
- BANK_AW, 8: address bits per bank; each bank is 2^BANK_AW words.
- N_BANKS, 4: number of banks; a power of two, at least 1.
- BASE_ADDR, 16'h0400: first address of the window; aligned to 2^BANK_AW.
- WP_MASK, 4'b1000: per-bank write-protect; bit i=1 rejects writes to bank i.

- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  one clock; reset is asynchronous and active-low.
- req  input  1  access request.
- we  input  1  1=write, 0=read; sampled with req.
- addr  input  ADDR_W  access address; sampled with req.
- din  input  DATA_W  write data; sampled with req.
- ready  output  1  block can accept a request.
- cs  output  N_BANKS  one-hot bank select, active during the access cycle.
- done  output  1  one-cycle pulse; marks the end of every accepted request.
- rvalid  output  1  one-cycle pulse with done; dout holds valid read data.
- err  output  1  one-cycle pulse with done; request rejected.
- dout  output  DATA_W  read data; holds its value until the next read response.
- err_cnt  output  8  saturating count of rejected requests.

## Operation
- Window: addresses BASE_ADDR through BASE_ADDR + N_BANKS·2^BANK_AW − 1. Defaults give 0x0400–0x07FF.
- Offset = addr − BASE_ADDR, computed in ADDR_W+1 bits so that addresses below the base are detected.
- Bank index = offset[BANK_AW +: log2(N_BANKS)]. Word index = offset[BANK_AW-1:0].
- Error conditions:
  - the address is outside the window (read or write);
  - a write targets a bank whose WP_MASK bit is set.
- FSM states and transitions:
  - IDLE: ready=1. Accepting req latches we, addr, din and the decode result, then moves to ACCESS.
  - ACCESS: for a valid access, cs[bank]=1 and the bank performs the write or registered read at the end of the cycle. For an error, cs stays 0 and memory is not touched. Moves to RESP.
  - RESP: done=1. If the access was a valid read, rvalid=1 and dout is updated with the bank output. If the access was an error, err=1, dout is unchanged and err_cnt increments unless already 255. Moves to IDLE.
- ready=0 in ACCESS and RESP. A req asserted outside IDLE is ignored; it is not queued.
- A valid write produces done only (rvalid=0, err=0).
- Reset values:
  - state=IDLE, ready=0 while rst_n=0 and 1 after release;
  - cs=0, done=0, rvalid=0, err=0, dout=0, err_cnt=0.
- RAM contents are not reset.
- Reset asserted mid-request aborts the request: no write is committed unless the ACCESS edge occurred before reset, and no response is produced.

## Timing
- Edge E0 samples req&&ready; this is the accept edge.
- The cycle after E0 is ACCESS; cs is asserted in this cycle.
- Edge E1 commits the write or captures the read data.
- The cycle after E1 is RESP; done, rvalid and err are visible here, and dout is valid in this cycle.
- Edge E2 returns the FSM to IDLE. The next request can be accepted at E3.
- Throughput: one request per 3 cycles. Latency from accept edge to response: 2 cycles.
- err_cnt updates at edge E2 for an error response.

## Structure
- Shared package/header sistema_mem_pkg holds:
  - state encoding IDLE/ACCESS/RESP (2 bits);
  - localparams WIN_SIZE = N_BANKS<<BANK_AW and BANK_SEL_W = log2(N_BANKS), or a clog2 function.
- Sub-module mem_bank: single-port synchronous RAM of DATA_W × 2^BANK_AW with en, we, addr, din and registered dout. It is instantiated N_BANKS times in a generate loop. Bank outputs are muxed by the latched bank index.

## Test plan
- Read-after-write, default parameters: write 0xAA at 0x0400, then read 0x0400 → done only on the write; on the read, cs=4'b0001 in ACCESS, and in RESP rvalid=1, dout=0xAA, err=0.
- Below-window write and read at 0x0200 (0xBB) → err=1 on both responses, cs never asserted, dout keeps 0xAA, err_cnt=2. A subsequent read of 0x0400 still returns 0xAA.
- Bank boundary and edge of window:
  - writes to 0x04FF (0x11) and 0x0500 (0x22) → cs=0001 and 0010 respectively, and read back correctly;
  - access at 0x0800 → err=1 (one past the window).
- Write-protect: write 0x55 at 0x0700 → err=1, err_cnt increments. A read of 0x0700 returns the prior contents with rvalid=1 (reads of protected banks are allowed).
- Handshake and reset:
  - req held high continuously → exactly one accept per 3 cycles; ready low in ACCESS and RESP.
  - rst_n pulsed low during ACCESS of a write → no done pulse; all outputs return to reset values; err_cnt=0.
  - 300 errors → err_cnt saturates at 255.

Source files
------------

// File: rtl/sistema_mem_02_pkg.sv
// Shared types and sizing helpers for the banked memory subsystem.
package sistema_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Bank index width; kept at least one bit so a single-bank build still declares legal vectors.
  function automatic int unsigned bank_sel_w(input int unsigned n_banks);
    return (n_banks > 1) ? $clog2(n_banks) : 1;
  endfunction

  function automatic int unsigned win_size(input int unsigned n_banks, input int unsigned bank_aw);
    return n_banks << bank_aw;
  endfunction

endpackage

// File: rtl/sistema_mem_02_if.sv
// Request/response bus between a simple master and the banked memory.
interface sistema_mem_02_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 16,
  parameter int N_BANKS = 4
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic              ready;
  logic [N_BANKS-1:0] cs;
  logic              done;
  logic              rvalid;
  logic              err;
  logic [DATA_W-1:0] dout;
  logic [7:0]        err_cnt;

  modport master (
    output req, we, addr, din,
    input  ready, cs, done, rvalid, err, dout, err_cnt
  );

  modport slave (
    input  req, we, addr, din,
    output ready, cs, done, rvalid, err, dout, err_cnt
  );
endinterface

// File: rtl/sistema_mem_02_mem_bank.sv
// Single-port synchronous RAM bank, registered read; one-cycle read latency, no backpressure.
module mem_bank #(
  parameter int DATA_W = 8,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end
endmodule

// File: rtl/sistema_mem_02.sv
// Banked memory with window decode, write-protect and error counting.
// Accept -> response in 2 cycles; ready drops for ACCESS and RESP, requests there are dropped.
module sistema_mem_02
  import sistema_mem_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 16,
  parameter int                BANK_AW   = 8,
  parameter int                N_BANKS   = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0400,
  parameter logic [N_BANKS-1:0] WP_MASK  = 4'b1000
) (
  input  logic             clk,
  input  logic             rst_n,
  sistema_mem_02_if.slave  bus
);
  localparam int unsigned     BSW = bank_sel_w(N_BANKS);
  localparam logic [ADDR_W:0] WIN = (ADDR_W+1)'(win_size(N_BANKS, BANK_AW));

  state_t state, state_nxt;

  logic [ADDR_W:0]    off;
  logic               in_win;
  logic [BSW-1:0]     dec_bank;
  logic [BANK_AW-1:0] dec_word;
  logic               dec_err;
  logic               accept;

  logic               lat_we;
  logic               lat_err;
  logic [BSW-1:0]     lat_bank;
  logic [BANK_AW-1:0] lat_word;
  logic [DATA_W-1:0]  lat_din;

  logic [DATA_W-1:0]  dout_q;
  logic [7:0]         err_cnt;
  logic [N_BANKS-1:0] cs_vec;
  logic               rd_ok;
  logic [DATA_W-1:0]  bank_q [N_BANKS];
  logic [DATA_W-1:0]  rd_dat;

  // One extra bit so addresses below the base wrap to a large value and fail the window test.
  assign off      = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
  assign in_win   = off < WIN;
  assign dec_bank = BSW'(off >> BANK_AW);
  assign dec_word = off[BANK_AW-1:0];
  assign dec_err  = !in_win || (bus.we && WP_MASK[dec_bank]);

  assign bus.ready = rst_n && (state == IDLE);
  assign accept    = bus.ready && bus.req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we   <= 1'b0;
      lat_err  <= 1'b0;
      lat_bank <= '0;
      lat_word <= '0;
      lat_din  <= '0;
    end else if (accept) begin
      lat_we   <= bus.we;
      lat_err  <= dec_err;
      lat_bank <= dec_bank;
      lat_word <= dec_word;
      lat_din  <= bus.din;
    end
  end

  assign rd_ok  = !lat_err && !lat_we;
  assign rd_dat = bank_q[lat_bank];
  assign cs_vec = (state == ACCESS && !lat_err) ? (N_BANKS'(1) << lat_bank) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      err_cnt <= '0;
    end else if (state == RESP) begin
      if (rd_ok) dout_q <= rd_dat;
      if (lat_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Read data is forwarded straight from the bank during RESP, then held in dout_q.
  assign bus.cs      = cs_vec;
  assign bus.done    = (state == RESP);
  assign bus.rvalid  = (state == RESP) && rd_ok;
  assign bus.err     = (state == RESP) && lat_err;
  assign bus.dout    = (state == RESP && rd_ok) ? rd_dat : dout_q;
  assign bus.err_cnt = err_cnt;

  for (genvar i = 0; i < N_BANKS; i++) begin : g_bank
    mem_bank #(.DATA_W(DATA_W), .AW(BANK_AW)) u_bank (
      .clk  (clk),
      .en   (cs_vec[i]),
      .we   (lat_we),
      .addr (lat_word),
      .din  (lat_din),
      .dout (bank_q[i])
    );
  end
endmodule

// File: tb/tb_sistema_mem_02.sv
// Directed bench for sistema_mem_02 with a transaction-level reference model.
module tb_sistema_mem_02;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sistema_mem_02_if #(.DATA_W(8), .ADDR_W(16), .N_BANKS(4)) bus ();

  sistema_mem_02 #(
    .DATA_W(8), .ADDR_W(16), .BANK_AW(8), .N_BANKS(4),
    .BASE_ADDR(16'h0400), .WP_MASK(4'b1000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, tracked by cycles since accept.
  int          ph = 0;
  logic        m_we = 1'b0;
  int          m_addr = 0;
  logic [7:0]  m_din = 8'h0;
  logic        m_bad = 1'b0;
  logic [7:0]  mmem [int];
  logic [7:0]  m_dout = 8'h0;
  bit          m_dout_known = 1'b1;
  int          m_cnt = 0;

  function automatic bit in_window(input int a);
    return (a >= 32'h400) && (a < 32'h800);
  endfunction

  function automatic int bank_of(input int a);
    return (a - 32'h400) / 256;
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      case (ph)
        2: begin
          if (m_bad) begin
            if (m_cnt < 255) m_cnt++;
          end else if (!m_we) begin
            m_dout_known = mmem.exists(m_addr);
            if (m_dout_known) m_dout = mmem[m_addr];
          end
          ph = 0;
        end
        1: begin
          if (!m_bad && m_we) mmem[m_addr] = m_din;
          ph = 2;
        end
        default: begin
          if (bus.req) begin
            m_we   = bus.we;
            m_addr = int'(bus.addr);
            m_din  = bus.din;
            m_bad  = !in_window(m_addr) || (m_we && bank_of(m_addr) == 3);
            ph     = 1;
          end
        end
      endcase
    end
  end

  always @(negedge rst_n) begin
    ph = 0;
    m_cnt = 0;
    m_dout = 8'h0;
    m_dout_known = 1'b1;
  end

  logic [7:0] last_dout = 8'h0;
  logic       last_err = 1'b0;
  logic       last_rv = 1'b0;
  logic [3:0] last_cs = 4'h0;

  always @(negedge clk) begin : cmp
    logic       e_rdy, e_done, e_rv, e_err;
    logic [3:0] e_cs;
    logic [7:0] e_dout;
    bit         dk;
    e_rdy  = rst_n && (ph == 0);
    e_cs   = (ph == 1 && !m_bad) ? 4'(1 << bank_of(m_addr)) : 4'b0000;
    e_done = (ph == 2);
    e_rv   = e_done && !m_bad && !m_we;
    e_err  = e_done && m_bad;
    if (e_rv) begin
      dk     = mmem.exists(m_addr);
      e_dout = dk ? mmem[m_addr] : 8'h00;
    end else begin
      dk     = m_dout_known;
      e_dout = m_dout;
    end
    chk("ready",   bus.ready,   e_rdy);
    chk("cs",      bus.cs,      e_cs);
    chk("done",    bus.done,    e_done);
    chk("rvalid",  bus.rvalid,  e_rv);
    chk("err",     bus.err,     e_err);
    chk("err_cnt", bus.err_cnt, m_cnt);
    if (dk) chk("dout", bus.dout, e_dout);
    if (bus.cs != 4'b0000) last_cs = bus.cs;
    if (bus.done) begin
      last_dout = bus.dout;
      last_err  = bus.err;
      last_rv   = bus.rvalid;
    end
  end

  // Issue one request from a negedge; returns at the negedge after the response.
  task automatic access(input logic w, input logic [15:0] a, input logic [7:0] d);
    int n = 0;
    last_cs = 4'b0000;
    while (!bus.ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", bus.ready, 1);
    bus.req  = 1'b1;
    bus.we   = w;
    bus.addr = a;
    bus.din  = d;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acc;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.din = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.ready, 0);
    chk("rst_dout",  bus.dout,  0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.ready, 1);

    // Read-after-write
    access(1'b1, 16'h0400, 8'hAA);
    chk("wr_err", last_err, 0);
    chk("wr_rvalid", last_rv, 0);
    access(1'b0, 16'h0400, 8'h00);
    chk("raw_cs", last_cs, 4'b0001);
    chk("raw_dout", last_dout, 8'hAA);
    chk("raw_rvalid", last_rv, 1);

    // Below the window
    access(1'b1, 16'h0200, 8'hBB);
    chk("below_wr_err", last_err, 1);
    access(1'b0, 16'h0200, 8'h00);
    chk("below_rd_err", last_err, 1);
    chk("below_cs", last_cs, 4'b0000);
    chk("below_cnt", bus.err_cnt, 2);
    chk("below_dout", bus.dout, 8'hAA);
    access(1'b0, 16'h0400, 8'h00);
    chk("reread_dout", last_dout, 8'hAA);

    // Bank boundary and window edge
    access(1'b1, 16'h04FF, 8'h11);
    chk("b0_top_cs", last_cs, 4'b0001);
    access(1'b1, 16'h0500, 8'h22);
    chk("b1_bot_cs", last_cs, 4'b0010);
    access(1'b0, 16'h04FF, 8'h00);
    chk("b0_top_dout", last_dout, 8'h11);
    access(1'b0, 16'h0500, 8'h00);
    chk("b1_bot_dout", last_dout, 8'h22);
    access(1'b0, 16'h0800, 8'h00);
    chk("past_win_err", last_err, 1);
    chk("past_win_cnt", bus.err_cnt, 3);

    // Write-protected bank
    access(1'b1, 16'h0700, 8'h55);
    chk("wp_err", last_err, 1);
    chk("wp_cs", last_cs, 4'b0000);
    chk("wp_cnt", bus.err_cnt, 4);
    access(1'b0, 16'h0700, 8'h00);
    chk("wp_rd_rvalid", last_rv, 1);
    chk("wp_rd_err", last_err, 0);
    chk("wp_rd_cs", last_cs, 4'b1000);
    access(1'b0, 16'h0400, 8'h00);

    // req held high: one accept every three cycles
    acc = 0;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0400;
    for (int i = 0; i < 30; i++) begin
      if (bus.ready) acc++;
      @(negedge clk);
    end
    bus.req = 1'b0;
    chk("accepts_30cyc", acc, 10);

    // Reset during ACCESS of a write
    access(1'b1, 16'h0401, 8'h33);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'h0401; bus.din = 8'h77;
    @(negedge clk);
    bus.req = 1'b0;
    chk("mid_cs", bus.cs, 4'b0001);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_done", bus.done, 0);
    chk("abort_cnt", bus.err_cnt, 0);
    chk("abort_dout", bus.dout, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    access(1'b0, 16'h0401, 8'h00);
    chk("abort_no_write", last_dout, 8'h33);

    // Saturation
    for (int i = 0; i < 300; i++) access(1'b1, 16'h0200, 8'h00);
    chk("sat_cnt", bus.err_cnt, 255);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
